// File: rtl/vault_phase_seq.sv
// vault_phase_seq: sequencer for the first three vault-escape phases
// (serial code, switch key, maze moves). Optional macro PHASE3_RETRY_EN:
// when defined, a failed maze sends the player back to the switch phase
// until MAX_RETRY failures have been used up; otherwise a maze failure locks.
module vault_phase_seq #(
    parameter logic [3:0]  P1_CODE = 4'b1011,
    parameter logic [3:0]  P2_KEY  = 4'b1101,
    parameter logic [14:0] P3_SEQ  = 15'b000_011_001_010_000
`ifdef PHASE3_RETRY_EN
    ,
    parameter int unsigned MAX_RETRY = 3
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       code_in,
    input  logic [3:0] switch_in,
    input  logic [2:0] dir_in,
    output logic       phase1_done,
    output logic       phase1_fail,
    output logic       phase1_alarm,
    output logic       phase2_done,
    output logic       phase2_fail,
    output logic       phase2_alarm,
    output logic       phase3_done,
    output logic       phase3_fail,
    output logic       phase3_alarm,
    output logic       start_phase2,
    output logic       vault_open,
    output logic       locked_out
);

    typedef enum logic [2:0] {
        S_P1   = 3'd0,
        S_P2   = 3'd1,
        S_P3   = 3'd2,
        S_OPEN = 3'd3,
        S_LOCK = 3'd4
    } state_t;

    state_t     state_q;
    logic [1:0] bit_idx_q;
    logic [2:0] move_idx_q;
    logic [1:0] rst_sync_q;
    logic       core_rst_n;
    logic [2:0] exp_move;

    logic phase1_done_q, phase1_fail_q, phase1_alarm_q;
    logic phase2_done_q, phase2_fail_q, phase2_alarm_q;
    logic phase3_done_q, phase3_fail_q, phase3_alarm_q;
    logic start_phase2_q, vault_open_q, locked_out_q;

`ifdef PHASE3_RETRY_EN
    // Wide enough to hold MAX_RETRY+1, the count that triggers lockout.
    localparam int RW = $clog2(MAX_RETRY + 2);
    logic [RW-1:0] retry_q;
`endif

    // Reset asserts asynchronously but is released only after two clock edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign core_rst_n = rst_sync_q[1];

    // Move expected at the current maze index; first move sits in the top bits.
    always_comb begin
        exp_move = P3_SEQ[2:0];
        case (move_idx_q)
            3'd0:    exp_move = P3_SEQ[14:12];
            3'd1:    exp_move = P3_SEQ[11:9];
            3'd2:    exp_move = P3_SEQ[8:6];
            3'd3:    exp_move = P3_SEQ[5:3];
            default: exp_move = P3_SEQ[2:0];
        endcase
    end

    // Phase FSM with registered sticky status flags; start=0 freezes progress.
    always_ff @(posedge clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_q        <= S_P1;
            bit_idx_q      <= 2'd0;
            move_idx_q     <= 3'd0;
            phase1_done_q  <= 1'b0;
            phase1_fail_q  <= 1'b0;
            phase1_alarm_q <= 1'b0;
            phase2_done_q  <= 1'b0;
            phase2_fail_q  <= 1'b0;
            phase2_alarm_q <= 1'b0;
            phase3_done_q  <= 1'b0;
            phase3_fail_q  <= 1'b0;
            phase3_alarm_q <= 1'b0;
            start_phase2_q <= 1'b0;
            vault_open_q   <= 1'b0;
            locked_out_q   <= 1'b0;
`ifdef PHASE3_RETRY_EN
            retry_q        <= '0;
`endif
        end else begin
            // The retry notice lasts exactly one cycle, even when paused.
            start_phase2_q <= 1'b0;
            if (start) begin
                case (state_q)
                    S_P1: begin
                        // Code is entered MSB first, so bit 3-idx == ~idx.
                        if (code_in == P1_CODE[~bit_idx_q]) begin
                            if (bit_idx_q == 2'd3) begin
                                phase1_done_q <= 1'b1;
                                state_q       <= S_P2;
                            end else begin
                                bit_idx_q <= bit_idx_q + 2'd1;
                            end
                        end else begin
                            phase1_fail_q  <= 1'b1;
                            phase1_alarm_q <= 1'b1;
                            locked_out_q   <= 1'b1;
                            state_q        <= S_LOCK;
                        end
                    end
                    S_P2: begin
                        if (switch_in == P2_KEY) begin
                            phase2_done_q <= 1'b1;
                            move_idx_q    <= 3'd0;
                            state_q       <= S_P3;
                        end else begin
                            phase2_fail_q  <= 1'b1;
                            phase2_alarm_q <= 1'b1;
                            locked_out_q   <= 1'b1;
                            state_q        <= S_LOCK;
                        end
                    end
                    S_P3: begin
                        if (dir_in == exp_move) begin
                            if (move_idx_q == 3'd4) begin
                                phase3_done_q <= 1'b1;
                                vault_open_q  <= 1'b1;
                                state_q       <= S_OPEN;
                            end else begin
                                move_idx_q <= move_idx_q + 3'd1;
                            end
                        end else begin
                            phase3_fail_q  <= 1'b1;
                            phase3_alarm_q <= 1'b1;
                            start_phase2_q <= 1'b1;
`ifdef PHASE3_RETRY_EN
                            retry_q <= retry_q + RW'(1);
                            // This failure pushes the count past the allowance.
                            if (retry_q >= RW'(MAX_RETRY)) begin
                                locked_out_q <= 1'b1;
                                state_q      <= S_LOCK;
                            end else begin
                                phase2_done_q <= 1'b0;
                                state_q       <= S_P2;
                            end
`else
                            locked_out_q <= 1'b1;
                            state_q      <= S_LOCK;
`endif
                        end
                    end
                    default: begin
                        // OPEN and LOCK ignore inputs until reset.
                    end
                endcase
            end
        end
    end

    assign phase1_done  = phase1_done_q;
    assign phase1_fail  = phase1_fail_q;
    assign phase1_alarm = phase1_alarm_q;
    assign phase2_done  = phase2_done_q;
    assign phase2_fail  = phase2_fail_q;
    assign phase2_alarm = phase2_alarm_q;
    assign phase3_done  = phase3_done_q;
    assign phase3_fail  = phase3_fail_q;
    assign phase3_alarm = phase3_alarm_q;
    assign start_phase2 = start_phase2_q;
    assign vault_open   = vault_open_q;
    assign locked_out   = locked_out_q;

endmodule

// File: tb/tb_vault_phase_seq.sv
// Testbench for vault_phase_seq: directed scenarios followed by random
// episodes, every edge checked against a phase-level reference model.
module tb_vault_phase_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       code_in = 1'b0;
    logic [3:0] switch_in = 4'd0;
    logic [2:0] dir_in = 3'd0;
    logic phase1_done, phase1_fail, phase1_alarm;
    logic phase2_done, phase2_fail, phase2_alarm;
    logic phase3_done, phase3_fail, phase3_alarm;
    logic start_phase2, vault_open, locked_out;

    int n_cmp = 0;
    int n_fail = 0;

    vault_phase_seq dut (
        .clk(clk), .reset(reset), .start(start), .code_in(code_in),
        .switch_in(switch_in), .dir_in(dir_in),
        .phase1_done(phase1_done), .phase1_fail(phase1_fail), .phase1_alarm(phase1_alarm),
        .phase2_done(phase2_done), .phase2_fail(phase2_fail), .phase2_alarm(phase2_alarm),
        .phase3_done(phase3_done), .phase3_fail(phase3_fail), .phase3_alarm(phase3_alarm),
        .start_phase2(start_phase2), .vault_open(vault_open), .locked_out(locked_out)
    );

    always #5 clk = ~clk;

    // Puzzle content written out from the spec's encodings
    // (UP=0, DOWN=1, LEFT=2, RIGHT=3).
    localparam logic [3:0] KEY = 4'b1101;
    localparam int MAXR = 3;
    localparam int PH_OPEN = 10;
    localparam int PH_LOCK = 20;
    bit         code_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0] move_seq [5] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd0};

    // Reference model: phase number, progress within phase, flag set.
    int m_phase, m_pos, m_retries;
    bit m_p1d, m_p1f, m_p1a, m_p2d, m_p2f, m_p2a, m_p3d, m_p3f, m_p3a, m_sp2, m_open, m_lock;

    function automatic logic [11:0] observed();
        return {phase1_done, phase1_fail, phase1_alarm, phase2_done, phase2_fail, phase2_alarm,
                phase3_done, phase3_fail, phase3_alarm, start_phase2, vault_open, locked_out};
    endfunction

    function automatic logic [11:0] expected();
        return {m_p1d, m_p1f, m_p1a, m_p2d, m_p2f, m_p2a,
                m_p3d, m_p3f, m_p3a, m_sp2, m_open, m_lock};
    endfunction

    task automatic model_reset();
        m_phase = 1; m_pos = 0; m_retries = 0;
        {m_p1d, m_p1f, m_p1a, m_p2d, m_p2f, m_p2a, m_p3d, m_p3f, m_p3a, m_sp2, m_open, m_lock} = '0;
    endtask

    task automatic model_edge(input bit s, input bit c, input logic [3:0] sw, input logic [2:0] d);
        m_sp2 = 1'b0;
        if (!s) return;
        if (m_phase == 1) begin
            if (c == code_seq[m_pos]) begin
                m_pos++;
                if (m_pos == 4) begin m_p1d = 1; m_phase = 2; end
            end else begin
                m_p1f = 1; m_p1a = 1; m_lock = 1; m_phase = PH_LOCK;
            end
        end else if (m_phase == 2) begin
            if (sw == KEY) begin m_p2d = 1; m_pos = 0; m_phase = 3; end
            else begin m_p2f = 1; m_p2a = 1; m_lock = 1; m_phase = PH_LOCK; end
        end else if (m_phase == 3) begin
            if (d == move_seq[m_pos]) begin
                m_pos++;
                if (m_pos == 5) begin m_p3d = 1; m_open = 1; m_phase = PH_OPEN; end
            end else begin
                m_p3f = 1; m_p3a = 1; m_sp2 = 1;
`ifdef PHASE3_RETRY_EN
                m_retries++;
                if (m_retries > MAXR) begin m_lock = 1; m_phase = PH_LOCK; end
                else begin m_p2d = 0; m_phase = 2; end
`else
                m_lock = 1; m_phase = PH_LOCK;
`endif
            end
        end
    endtask

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %03h expected %03h", tag, got, want);
        end
    endtask

    // One clock edge with the given inputs, checked against the model.
    task automatic step(input bit s, input bit c, input logic [3:0] sw, input logic [2:0] d);
        start = s; code_in = c; switch_in = sw; dir_in = d;
        @(posedge clk);
        model_edge(s, c, sw, d);
        #1;
        check("edge", observed(), expected());
        $display("step start=%0b code=%0b sw=%h dir=%0d -> out=%03h", s, c, sw, d, observed());
    endtask

    // Async assert (outputs must clear at once), then a clean release.
    task automatic apply_reset();
        reset = 1'b0;
        #1;
        check("reset_clear", observed(), 12'h000);
        model_reset();
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (3) step(1'b0, 1'b0, 4'd0, 3'd0);
    endtask

    task automatic do_code();
        for (int i = 0; i < 4; i++) step(1'b1, code_seq[i], 4'd0, 3'd0);
    endtask

    task automatic do_moves();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'd0, move_seq[i]);
    endtask

    task automatic fail_maze();
        step(1'b1, 1'b0, 4'd0, 3'd0);  // UP
        step(1'b1, 1'b0, 4'd0, 3'd2);  // LEFT instead of RIGHT
        check("sp2_pulse", 12'(start_phase2), 12'd1);
        check("p3_fail", 12'({phase3_fail, phase3_alarm}), 12'd3);
        step(1'b0, 1'b0, 4'd0, 3'd0);
        check("sp2_one_cycle", 12'(start_phase2), 12'd0);
    endtask

    initial begin
        bit s, w, c;
        logic [3:0] sw;
        logic [2:0] d;
        model_reset();
        #3;
        check("reset_start", observed(), 12'h000);
        apply_reset();

        // Full correct run.
        step(1'b1, 1'b1, 4'd0, 3'd0);
        step(1'b1, 1'b0, 4'd0, 3'd0);
        step(1'b1, 1'b1, 4'd0, 3'd0);
        check("p1_not_early", 12'(phase1_done), 12'd0);
        step(1'b1, 1'b1, 4'd0, 3'd0);
        check("p1_done_edge4", 12'({phase1_done, phase1_fail, phase1_alarm}), 12'b100);
        step(1'b1, 1'b0, KEY, 3'd0);
        check("p2_done_edge5", 12'(phase2_done), 12'd1);
        do_moves();
        check("open_edge10", 12'({phase3_done, vault_open, start_phase2, locked_out}), 12'b1100);
        repeat (3) step(1'b1, 1'b0, 4'hF, 3'd7);  // ignored in OPEN
        check("open_held", 12'(vault_open), 12'd1);

        // Wrong second code bit.
        apply_reset();
        step(1'b1, 1'b1, 4'd0, 3'd0);
        step(1'b1, 1'b1, 4'd0, 3'd0);
        check("p1_fail_lock", 12'({phase1_done, phase1_fail, phase1_alarm, locked_out}), 12'b0111);

        // Wrong switch key.
        apply_reset();
        do_code();
        step(1'b1, 1'b0, 4'b1010, 3'd0);
        check("p2_fail_lock", 12'({phase2_done, phase2_fail, phase2_alarm, locked_out}), 12'b0111);

        // Pause mid-code for three cycles.
        apply_reset();
        step(1'b1, 1'b1, 4'd0, 3'd0);
        step(1'b1, 1'b0, 4'd0, 3'd0);
        repeat (3) step(1'b0, 1'b0, 4'd0, 3'd0);
        step(1'b1, 1'b1, 4'd0, 3'd0);
        check("pause_no_done", 12'(phase1_done), 12'd0);
        step(1'b1, 1'b1, 4'd0, 3'd0);
        check("pause_done", 12'(phase1_done), 12'd1);

        // Maze failure and retry behaviour.
        apply_reset();
        do_code();
        step(1'b1, 1'b0, KEY, 3'd0);
        fail_maze();
`ifdef PHASE3_RETRY_EN
        check("retry_p2_cleared", 12'({phase2_done, locked_out}), 12'b00);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, KEY, 3'd0);
            check("retry_p2_again", 12'(phase2_done), 12'd1);
            fail_maze();
        end
        check("retry_lock", 12'(locked_out), 12'd1);
`else
        check("no_retry_lock", 12'(locked_out), 12'd1);
`endif

        // Reset in the middle of phase 3, then a full pass again.
        apply_reset();
        do_code();
        step(1'b1, 1'b0, KEY, 3'd0);
        step(1'b1, 1'b0, 4'd0, 3'd0);
        step(1'b1, 1'b0, 4'd0, 3'd3);
        apply_reset();
        do_code();
        step(1'b1, 1'b0, KEY, 3'd0);
        do_moves();
        check("reopen_after_reset", 12'(vault_open), 12'd1);

        // Random episodes, mostly-correct inputs with occasional pauses and errors.
        for (int ep = 0; ep < 40; ep++) begin
            apply_reset();
            for (int k = 0; k < 30; k++) begin
                s  = ($urandom_range(0, 9) != 0);
                w  = ($urandom_range(0, 11) == 0);
                c  = 1'($urandom_range(0, 1));
                sw = 4'($urandom_range(0, 15));
                d  = 3'($urandom_range(0, 7));
                if (m_phase == 1) c = code_seq[m_pos] ^ w;
                if (m_phase == 2) sw = w ? (KEY ^ 4'($urandom_range(1, 15))) : KEY;
                if (m_phase == 3) d = w ? (move_seq[m_pos] ^ 3'($urandom_range(1, 7))) : move_seq[m_pos];
                step(s, c, sw, d);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vault_phase_seq.md
# vault_phase_seq

Sequencer for the first three vault-escape puzzle phases: a 4-bit serial code (phase 1), a parallel switch key (phase 2) and a 5-step maze direction sequence (phase 3). It runs the phases in order, reports per-phase done/fail/alarm status, and retries phase 2 when the maze is failed. It sits between the player input pins and the later phases, which start from `vault_open`.

## Interface
- `P1_CODE`, 4'b1011: serial code, MSB entered first.
- `P2_KEY`, 4'b1101: required `switch_in` value.
- `P3_SEQ`, 15'b000_011_001_010_000: five 3-bit moves, first move in bits [14:12]; encoding UP=000, DOWN=001, LEFT=010, RIGHT=011.
- `MAX_RETRY`, 3: number of phase-3 failures allowed before lockout (used only with `PHASE3_RETRY_EN`).
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: level enable; the sequencer advances only on edges where `start`=1.
- `code_in` in 1: phase-1 serial code bit.
- `switch_in` in 4: phase-2 switch key.
- `dir_in` in 3: phase-3 direction.
- `phase1_done`, `phase1_fail`, `phase1_alarm` out 1: phase-1 status.
- `phase2_done`, `phase2_fail`, `phase2_alarm` out 1: phase-2 status.
- `phase3_done`, `phase3_fail`, `phase3_alarm` out 1: phase-3 status.
- `start_phase2` out 1: one-cycle pulse; the phase-3 failure is returning to phase 2.
- `vault_open` out 1: all three phases passed.
- `locked_out` out 1: terminal failure.

## Operation
- States: P1, P2, P3, OPEN, LOCK. Reset enters P1 with the bit and move indices at 0.
- P1: each edge with `start`=1 compares `code_in` with `P1_CODE[3-idx]`.
  - Match, idx<3: idx++.
  - Match, idx=3: set `phase1_done`, go to P2.
  - Mismatch: set `phase1_fail` and `phase1_alarm`, go to LOCK.
  - No partial-credit restart.
- P2: first edge with `start`=1 compares `switch_in` with `P2_KEY`.
  - Equal: set `phase2_done`, clear the move index, go to P3.
  - Not equal: set `phase2_fail` and `phase2_alarm`, go to LOCK.
- P3: each edge with `start`=1 compares `dir_in` with the move at the current index.
  - Match, idx<4: idx++.
  - Match, idx=4: set `phase3_done` and `vault_open`, go to OPEN.
  - Mismatch: set `phase3_fail` and `phase3_alarm`, pulse `start_phase2`, then apply the retry rule (see Configuration).
- OPEN and LOCK: terminal; inputs are ignored until reset.
- `start`=0 in any state: hold the state, indices and outputs (pause, no reset of progress).
- Done, fail and alarm flags are sticky until reset, except that `phase2_done` clears when phase 2 is re-entered on retry.
- `locked_out` is 1 exactly while in LOCK.

## Timing
- Reset: every output is 0 immediately (asynchronous). Deassertion is synchronised internally: two-flop release on `clk`.
- All flags are registered and asserted on the same edge that samples the deciding input.
- Inputs are sampled on the rising edge; the bench changes them away from the edge.
- Phase transitions take effect on the deciding edge, so the next phase samples on the following edge.
- Fully correct run with `start` held high: `phase1_done` after edge 4, `phase2_done` after edge 5, `vault_open` after edge 10.
- Failure latency: fail/alarm assert on the edge sampling the first wrong value (no waiting for the full sequence).
- `start_phase2` is high for exactly the one cycle following the failing edge.
- Reset asserted mid-sequence: all progress and retry count are discarded at once.

## Configuration
- `PHASE3_RETRY_EN` defined:
  - Phase-3 mismatch returns to P2, clears `phase2_done`, and increments the retry counter.
  - `phase3_fail` and `phase3_alarm` remain set.
  - The mismatch that makes the counter exceed `MAX_RETRY` goes to LOCK instead. `start_phase2` is still pulsed on that edge.
- `PHASE3_RETRY_EN` undefined:
  - Phase-3 mismatch goes to LOCK.
  - `start_phase2` still pulses once, as an informational signal.
  - No retry counter is built.

## Test plan
- Code 1,0,1,1 -> `phase1_done`=1 after edge 4; `phase1_fail`=0; `phase1_alarm`=0.
- Code 1,1,... -> `phase1_fail`=1, `phase1_alarm`=1 and `locked_out`=1 after edge 2; `phase1_done` stays 0.
- Correct code, then `switch_in`=1101 -> `phase2_done`=1 after edge 5. With `switch_in`=1010 instead -> `phase2_fail`=1, `phase2_alarm`=1, LOCK.
- Full path with moves UP, RIGHT, DOWN, LEFT, UP -> `phase3_done`=1 and `vault_open`=1 after edge 10; all alarms 0; `start_phase2` never pulses.
- Phase 3 moves UP, LEFT -> `phase3_fail`=1, `phase3_alarm`=1, `start_phase2` a 1-cycle pulse.
  - With `PHASE3_RETRY_EN`: back in P2, `switch_in`=1101 re-passes; the fourth maze failure gives `locked_out`=1.
  - Without it: `locked_out`=1 immediately.
- Drop `start` for 3 cycles mid-code, then resume -> progress is held and `phase1_done` still follows the 4th correct bit. Assert `reset` mid-phase-3 -> all outputs 0 at once and the sequence restarts in P1.
